// File: rtl/sr04_pkg.sv
// Shared definitions for the HC-SR04 ultrasonic ranging controller:
// FSM state encoding, default timing constants and counter-width helpers.
package sr04_pkg;

  // Default timing constants (system clock and sensor protocol).
  localparam int DEF_CLK_FREQ_HZ     = 100_000_000;
  localparam int DEF_TRIG_US         = 10;
  localparam int DEF_ECHO_TIMEOUT_US = 25_000;
  localparam int DEF_US_PER_CM       = 58;
  localparam int DEF_MAX_CM          = 400;

  // Distance bus width; the display stage takes exactly this many bits.
  localparam int DIST_W = 9;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_DONE
  } state_t;

  // Bits needed for a counter that runs 0..v-1 (at least one bit).
  function automatic int cnt_width(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen_us.sv
// Microsecond tick generator: divides clk by CLK_FREQ_HZ/1_000_000.
// The tick fires on the last clk of every microsecond window; 'clear'
// restarts the window so that a new FSM state always begins with a full
// microsecond before its first tick.
module tick_gen_us
  import sr04_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int CW  = cnt_width(DIV);

  logic [CW-1:0] div_cnt;

  // Divider counter: wraps at DIV-1, restarts on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear || (div_cnt == CW'(DIV - 1))) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // The tick is not gated by clear: a tick landing on a state's final
  // cycle still belongs to that state.
  assign tick = (div_cnt == CW'(DIV - 1));

endmodule

// File: rtl/sr04_controller.sv
// HC-SR04 ultrasonic ranging controller.
// On an accepted start it issues a TRIG_US trigger pulse, waits for the
// echo to rise, times the echo high period in microseconds and converts
// it to centimetres (US_PER_CM us per cm, saturating at MAX_CM).
// Missing or stuck echoes raise a sticky error and return to IDLE with
// the previous distance preserved.
module sr04_controller
  import sr04_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = DEF_CLK_FREQ_HZ,
  parameter int TRIG_US         = DEF_TRIG_US,
  parameter int ECHO_TIMEOUT_US = DEF_ECHO_TIMEOUT_US,
  parameter int US_PER_CM       = DEF_US_PER_CM,
  parameter int MAX_CM          = DEF_MAX_CM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              busy,
  output logic              error
);

  localparam int US_W  = cnt_width(max_int(TRIG_US, ECHO_TIMEOUT_US));
  localparam int SUB_W = cnt_width(US_PER_CM);

  logic              echo_meta;
  logic              echo_sync;
  state_t            state;
  state_t            state_next;
  logic              state_entry;
  logic              measure_entry;
  logic              tick;
  logic [US_W-1:0]   us_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [DIST_W-1:0] cm_count;
  logic              trig_done;
  logic              us_timeout;
  logic              start_accept;
  logic              timeout_abort;

  // Two-flop synchronizer bringing the asynchronous echo into clk.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so the second flop samples the first
    // flop's pre-edge value; blocking here would collapse the chain.
    if (reset) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  assign state_entry   = (state_next != state);
  assign measure_entry = state_entry && (state_next == ST_MEASURE);

  tick_gen_us #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick_gen_us (
    .clk  (clk),
    .reset(reset),
    .clear(state_entry),
    .tick (tick)
  );

  // Microseconds spent in the current state; restarts on every state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      us_cnt <= '0;
    end else if (state_entry) begin
      us_cnt <= '0;
    end else if (tick && (state != ST_IDLE)) begin
      us_cnt <= us_cnt + US_W'(1);
    end
  end

  assign trig_done  = tick && (us_cnt == US_W'(TRIG_US - 1));
  assign us_timeout = tick && (us_cnt == US_W'(ECHO_TIMEOUT_US - 1));

  // Echo-width to centimetre conversion: sub_cnt counts microseconds
  // within one centimetre, cm_count counts whole centimetres.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_cnt  <= '0;
      cm_count <= '0;
    end else if (measure_entry) begin
      sub_cnt  <= '0;
      cm_count <= '0;
    end else if ((state == ST_MEASURE) && tick) begin
      if (sub_cnt == SUB_W'(US_PER_CM - 1)) begin
        sub_cnt <= '0;
        if (cm_count != DIST_W'(MAX_CM)) begin
          cm_count <= cm_count + DIST_W'(1);
        end
      end else begin
        sub_cnt <= sub_cnt + SUB_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. An echo edge takes priority over a coincident timeout.
  always_comb begin
    // NOTE: default first so every path assigns state_next; a missing
    // branch would otherwise infer a latch.
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_TRIG;
      end
      ST_TRIG: begin
        if (trig_done) state_next = ST_WAIT_ECHO;
      end
      ST_WAIT_ECHO: begin
        if (echo_sync)       state_next = ST_MEASURE;
        else if (us_timeout) state_next = ST_IDLE;
      end
      ST_MEASURE: begin
        if (!echo_sync)      state_next = ST_DONE;
        else if (us_timeout) state_next = ST_IDLE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode: busy flag and the events that set or clear error.
  always_comb begin
    busy          = (state != ST_IDLE);
    start_accept  = (state == ST_IDLE) && start;
    timeout_abort = 1'b0;
    if ((state == ST_WAIT_ECHO) && !echo_sync && us_timeout) begin
      timeout_abort = 1'b1;
    end
    if ((state == ST_MEASURE) && echo_sync && us_timeout) begin
      timeout_abort = 1'b1;
    end
  end

  // Registered outputs: trigger, result capture with its valid pulse,
  // and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig       <= 1'b0;
      distance   <= '0;
      dist_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      trig       <= (state_next == ST_TRIG);
      dist_valid <= (state == ST_DONE);
      if (state == ST_DONE) begin
        distance <= cm_count;
      end
      if (start_accept) begin
        error <= 1'b0;
      end else if (timeout_abort) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr04_controller.sv
// Self-checking bench for sr04_controller. Timing parameters are scaled
// down (4 clk per us, shorter timeout and saturation) to keep runs short;
// expected distances come from min(floor(echo_us / US_PER_CM), MAX_CM).
module tb_sr04_controller;

  localparam int CLK_HZ  = 4_000_000;
  localparam int DIV     = CLK_HZ / 1_000_000;
  localparam int TRIG_US = 10;
  localparam int TO_US   = 1500;
  localparam int UPC     = 58;
  localparam int MAXC    = 22;
  localparam int HALF    = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       echo;
  logic       trig;
  logic [8:0] distance;
  logic       dist_valid;
  logic       busy;
  logic       error;

  int checks    = 0;
  int errors    = 0;
  int dv_count  = 0;
  int last_dist = 0;

  sr04_controller #(
    .CLK_FREQ_HZ    (CLK_HZ),
    .TRIG_US        (TRIG_US),
    .ECHO_TIMEOUT_US(TO_US),
    .US_PER_CM      (UPC),
    .MAX_CM         (MAXC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .echo      (echo),
    .trig      (trig),
    .distance  (distance),
    .dist_valid(dist_valid),
    .busy      (busy),
    .error     (error)
  );

  always #HALF clk = ~clk;

  // Count every dist_valid cycle so stray or duplicate pulses are visible.
  always @(negedge clk) if (dist_valid === 1'b1) dv_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  // Reference: echo high for h clk cycles -> whole microseconds -> cm.
  function automatic int model_distance(input int h);
    int us;
    int cm;
    us = h / DIV;
    cm = us / UPC;
    return (cm > MAXC) ? MAXC : cm;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_trig_low();
    int n;
    n = 0;
    while (trig === 1'b1 && n < TRIG_US * DIV + 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (trig !== 1'b0) begin
      errors++;
      $display("FAIL trig_release: trig=%b after %0d cycles, expected 0", trig, n);
    end
  endtask

  // Drive one echo pulse of h cycles and check the resulting measurement.
  task automatic run_echo(input int h, input string name);
    int gap;
    int n;
    int exp_d;
    exp_d = model_distance(h);
    gap = $urandom_range(15, 0);
    repeat (gap) @(negedge clk);
    echo = 1'b1;
    repeat (h) @(negedge clk);
    echo = 1'b0;
    n = 0;
    while (dist_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dist_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: dist_valid=%b, expected 1 within 60 cycles", name, dist_valid);
    end else begin
      checks++;
      if (distance !== 9'(exp_d)) begin
        errors++;
        $display("FAIL %s_distance: got %0d expected %0d (echo %0d cycles)", name, distance, exp_d, h);
      end
      checks++;
      if (error !== 1'b0) begin
        errors++;
        $display("FAIL %s_error: error=%b expected 0", name, error);
      end
      @(negedge clk);
      checks++;
      if (dist_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_pulse_width: dist_valid=%b expected 0 on second cycle", name, dist_valid);
      end
    end
    last_dist = exp_d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    echo  = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (trig !== 1'b0)       begin errors++; $display("FAIL reset_trig: got %b expected 0", trig); end
    checks++; if (distance !== 9'd0)   begin errors++; $display("FAIL reset_distance: got %0d expected 0", distance); end
    checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL reset_dist_valid: got %b expected 0", dist_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (error !== 1'b0)      begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_trigger();
    int n;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1;
    checks++;
    if (trig !== 1'b0) begin
      errors++;
      $display("FAIL trig_before_start: got %b expected 0", trig);
    end
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (trig === 1'b1 && n < TRIG_US * DIV + 10) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TRIG_US * DIV) begin
      errors++;
      $display("FAIL trig_width: got %0d cycles expected %0d", n, TRIG_US * DIV);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL trig_busy: busy dropped during trigger, expected 1 throughout");
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_echo_busy: got %b expected 1", busy);
    end
    run_echo(580 * DIV, "d580");
    do_start();
    wait_trig_low();
    run_echo(1160 * DIV, "d1160");
  endtask

  task automatic test_boundaries();
    int hs [5];
    hs[0] = 1400 * DIV;        // past saturation
    hs[1] = DIV - 1;           // shorter than one tick
    hs[2] = UPC * DIV - 1;     // just under 1 cm
    hs[3] = UPC * DIV;         // exactly 1 cm
    hs[4] = MAXC * UPC * DIV;  // exactly the saturation value
    foreach (hs[i]) begin
      do_start();
      wait_trig_low();
      run_echo(hs[i], $sformatf("bound%0d", i));
    end
  endtask

  task automatic test_random();
    int h;
    for (int i = 0; i < 5; i++) begin
      h = $urandom_range(1000 * DIV, 1);
      do_start();
      wait_trig_low();
      run_echo(h, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back_start();
    int dv0;
    int h;
    int exp_d;
    h = 700 * DIV;
    exp_d = model_distance(h);
    dv0 = dv_count;
    do_start();
    repeat (5) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_trig_low();
    echo = 1'b1;
    repeat (150) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (h - 152) @(negedge clk);
    echo = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (dv_count - dv0 != 1) begin
      errors++;
      $display("FAIL ignore_start_results: got %0d results expected 1", dv_count - dv0);
    end
    checks++;
    if (distance !== 9'(exp_d)) begin
      errors++;
      $display("FAIL ignore_start_distance: got %0d expected %0d", distance, exp_d);
    end
    checks++;
    if (busy !== 1'b0 || trig !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_idle: busy=%b trig=%b expected 0 0", busy, trig);
    end
    last_dist = exp_d;
  endtask

  task automatic test_wait_timeout();
    int n;
    int dv0;
    dv0 = dv_count;
    do_start();
    wait_trig_low();
    n = 0;
    while (busy === 1'b1 && n < TO_US * DIV + 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TO_US * DIV) begin
      errors++;
      $display("FAIL wait_timeout_cycles: got %0d expected %0d", n, TO_US * DIV);
    end
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL wait_timeout_error: got %b expected 1", error);
    end
    checks++;
    if (distance !== 9'(last_dist)) begin
      errors++;
      $display("FAIL wait_timeout_distance: got %0d expected %0d", distance, last_dist);
    end
    checks++;
    if (dv_count != dv0) begin
      errors++;
      $display("FAIL wait_timeout_valid: got %0d pulses expected 0", dv_count - dv0);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky: got %b expected 1", error);
    end
    do_start();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear_on_start: got %b expected 0", error);
    end
    wait_trig_low();
    run_echo($urandom_range(1000 * DIV, 1), "after_timeout");
  endtask

  task automatic test_measure_timeout();
    int n;
    int dv0;
    dv0 = dv_count;
    do_start();
    wait_trig_low();
    echo = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < (TO_US + 20) * DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stuck_echo_busy: got %b expected 0", busy);
    end
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL stuck_echo_error: got %b expected 1", error);
    end
    checks++;
    if (distance !== 9'(last_dist)) begin
      errors++;
      $display("FAIL stuck_echo_distance: got %0d expected %0d", distance, last_dist);
    end
    echo = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (dv_count != dv0) begin
      errors++;
      $display("FAIL stuck_echo_valid: got %0d pulses expected 0", dv_count - dv0);
    end
  endtask

  task automatic test_reset_mid();
    int dv0;
    do_start();
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (trig !== 1'b0) begin
      errors++;
      $display("FAIL reset_trig_async: got %b expected 0", trig);
    end
    @(negedge clk);
    reset = 1'b0;
    do_start();
    wait_trig_low();
    dv0 = dv_count;
    echo = 1'b1;
    repeat (400) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
    checks++; if (distance !== 9'd0)   begin errors++; $display("FAIL reset_mid_distance: got %0d expected 0", distance); end
    checks++; if (dist_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_dist_valid: got %b expected 0", dist_valid); end
    checks++; if (error !== 1'b0)      begin errors++; $display("FAIL reset_mid_error: got %b expected 0", error); end
    checks++; if (trig !== 1'b0)       begin errors++; $display("FAIL reset_mid_trig: got %b expected 0", trig); end
    last_dist = 0;
    @(negedge clk);
    echo = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (dv_count != dv0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: pulses=%0d busy=%b expected 0 0", dv_count - dv0, busy);
    end
    do_start();
    wait_trig_low();
    run_echo($urandom_range(1000 * DIV, UPC * DIV), "after_reset");
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_boundaries();
    test_random();
    test_back_to_back_start();
    test_wait_timeout();
    test_measure_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr04_controller.md
SR04_CONTROLLER -- requirements
Module: sr04_controller

Interface
REQ-001 Parameter CLK_FREQ_HZ, 100_000_000, system clock frequency.
REQ-002 Parameter TRIG_US, 10, trigger pulse width in microseconds.
REQ-003 Parameter ECHO_TIMEOUT_US, 25_000, max wait for echo rise, and max echo high time, in microseconds.
REQ-004 Parameter US_PER_CM, 58, echo microseconds per centimetre.
REQ-005 Parameter MAX_CM, 400, distance saturation value.
REQ-006 clk  input  1  system clock, rising-edge active.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  measurement request, sampled high on a rising clk edge.
REQ-009 echo  input  1  sensor echo, asynchronous to clk.
REQ-010 trig  output  1  sensor trigger pulse, registered.
REQ-011 distance  output  9  last valid distance in cm, unsigned; the display stage consumes this directly.
REQ-012 dist_valid  output  1  one-cycle pulse when distance updates.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 error  output  1  timeout flag, sticky until the next accepted start.

Function
REQ-015 echo SHALL pass through a 2-flop synchronizer; all echo decisions use the synchronized value.
REQ-016 A 1 us tick SHALL be derived by dividing clk by CLK_FREQ_HZ/1_000_000; the divider clears on every state entry.
REQ-017 FSM states: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
REQ-018 IDLE: start=1 -> TRIG; clear error; trig rises the following cycle.
REQ-019 TRIG: trig=1 for exactly TRIG_US ticks (1000 clk at defaults), then -> WAIT_ECHO with trig=0.
REQ-020 WAIT_ECHO: synchronized echo=1 -> MEASURE (echo already high on entry counts as a rise); ECHO_TIMEOUT_US ticks elapse with no rise -> error=1, -> IDLE.
REQ-021 MEASURE: a us-per-cm sub-counter counts ticks 0..US_PER_CM-1; on wrap it increments cm_count, saturating at MAX_CM.
REQ-022 MEASURE: synchronized echo=0 -> DONE; echo high for ECHO_TIMEOUT_US ticks -> error=1, -> IDLE, distance unchanged.
REQ-023 DONE: distance <= cm_count, giving distance = min(floor(echo_us/US_PER_CM), MAX_CM); dist_valid=1 for that single cycle; -> IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 cm_count and the sub-counter SHALL clear on entry to MEASURE.
REQ-026 distance SHALL hold its value between measurements and on error.
REQ-027 An echo pulse shorter than 1 tick yields distance=0 with dist_valid=1.

Reset
REQ-028 reset=1 forces IDLE immediately, independent of clk.
REQ-029 Reset values: trig=0, distance=0, dist_valid=0, busy=0, error=0; all counters and synchronizer flops 0.
REQ-030 Reset mid-measurement aborts the measurement with no dist_valid pulse, and trig drops immediately.

Structure
REQ-031 A shared package sr04_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-032 The 1 us divider SHALL be a sub-module named tick_gen_us (clk, reset, clear, tick).
REQ-033 The distance width of 9 bits SHALL match the display stage's input width.

Verification
REQ-034 start pulse -> trig high 1 cycle later for exactly 1000 cycles, busy=1 throughout.
REQ-035 echo high 580 us -> distance=10, dist_valid single pulse, error=0; echo high 1160 us -> distance=20.
REQ-036 echo high 24_000 us -> distance=400 (saturated), error=0.
REQ-037 echo never rises -> error=1 after 25_000 us in WAIT_ECHO, back to IDLE, distance unchanged.
REQ-038 start re-pulsed mid-MEASURE -> ignored; a single result is produced.
REQ-039 reset asserted mid-MEASURE -> all outputs 0 asynchronously, no dist_valid; the next start measures normally.
